// File: rtl/fft_mag_reader.sv
// Sync FIFO with show-ahead read port; rd_dat is valid whenever rd_vld is high.
// Latency: one cycle from write to rd_vld.
// Backpressure: holds the head entry while rd_rdy is low; writes are ignored when full.
module fft_mag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    assign push   = wr_vld && (cnt != CW'(DEPTH));
    assign pop    = rd_rdy && (cnt != '0);
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign count  = cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// Sweeps all FFT bins from the DPRAM, streams |X[k]|^2 and reports the peak bin at frame end.
// Latency: start -> first ram_ren 1 cycle; ram_ren -> mag_valid 2 cycles; 1 bin/cycle sustained.
// Backpressure: mag_ready low fills the output FIFO, which throttles RAM reads; nothing is dropped.
module fft_mag_reader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int BITREV_ADDR = 0,
    parameter int SEARCH_HALF = 1,
    parameter int SKIP_DC     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      ram_ren,
    output logic [ADDR_WIDTH-1:0]     ram_raddr,
    input  logic [2*DATA_WIDTH-1:0]   ram_rdata,
    output logic                      mag_valid,
    input  logic                      mag_ready,
    output logic [2*DATA_WIDTH:0]     mag_data,
    output logic [ADDR_WIDTH-1:0]     mag_bin,
    output logic                      mag_last,
    output logic                      peak_valid,
    output logic [ADDR_WIDTH-1:0]     peak_bin,
    output logic [2*DATA_WIDTH:0]     peak_mag,
    output logic                      busy
);
    localparam int MW = 2*DATA_WIDTH + 1;
    localparam int PW = 1 + ADDR_WIDTH + MW;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] FIRST_BIN = (SKIP_DC != 0) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READ   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    logic [1:0]                   state;
    logic [ADDR_WIDTH-1:0]        rd_k;
    logic [ADDR_WIDTH-1:0]        wr_k;
    logic                         rd_inflight;
    logic [MW-1:0]                pk_mag_w;
    logic [ADDR_WIDTH-1:0]        pk_bin_w;
    logic [CW-1:0]                fifo_count;
    logic [CW:0]                  occ;
    logic                         issue;
    logic                         in_search;
    logic                         pop_last;
    logic                         f_vld;
    logic [PW-1:0]                f_dat;
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
    logic signed [2*DATA_WIDTH-1:0] re_x;
    logic signed [2*DATA_WIDTH-1:0] im_x;
    logic signed [2*DATA_WIDTH-1:0] sq_re;
    logic signed [2*DATA_WIDTH-1:0] sq_im;
    logic [MW-1:0]                mag_sum;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            r[i] = a[ADDR_WIDTH-1-i];
        end
        return r;
    endfunction

    // Occupancy counts FIFO entries plus the read whose data is still on the RAM port.
    assign occ       = {1'b0, fifo_count} + {{CW{1'b0}}, rd_inflight};
    assign issue     = (state == S_READ) && (occ < (CW+1)'(FIFO_DEPTH));
    assign ram_ren   = issue;
    assign ram_raddr = (BITREV_ADDR != 0) ? bitrev(rd_k) : rd_k;

    // Squares of a signed value never exceed 2^(2W-2), so the signed product fits and is non-negative.
    assign re      = ram_rdata[DATA_WIDTH-1:0];
    assign im      = ram_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign re_x    = {{DATA_WIDTH{re[DATA_WIDTH-1]}}, re};
    assign im_x    = {{DATA_WIDTH{im[DATA_WIDTH-1]}}, im};
    assign sq_re   = re_x * re_x;
    assign sq_im   = im_x * im_x;
    assign mag_sum = {1'b0, sq_re} + {1'b0, sq_im};

    always_comb begin
        in_search = 1'b1;
        if ((SKIP_DC != 0) && (wr_k == '0)) begin
            in_search = 1'b0;
        end
        if ((SEARCH_HALF != 0) && wr_k[ADDR_WIDTH-1]) begin
            in_search = 1'b0;
        end
    end

    fft_mag_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (rd_inflight),
        .wr_dat ({(&wr_k), wr_k, mag_sum}),
        .rd_vld (f_vld),
        .rd_rdy (mag_ready),
        .rd_dat (f_dat),
        .count  (fifo_count)
    );

    assign mag_valid  = f_vld;
    assign mag_data   = f_vld ? f_dat[MW-1:0] : '0;
    assign mag_bin    = f_vld ? f_dat[MW +: ADDR_WIDTH] : '0;
    assign mag_last   = f_vld & f_dat[PW-1];
    assign pop_last   = mag_valid && mag_ready && mag_last;
    assign peak_valid = (state == S_REPORT);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rd_k        <= '0;
            wr_k        <= '0;
            rd_inflight <= 1'b0;
            pk_mag_w    <= '0;
            pk_bin_w    <= '0;
            peak_bin    <= '0;
            peak_mag    <= '0;
        end else begin
            rd_inflight <= issue;
            if (rd_inflight) begin
                wr_k <= wr_k + ADDR_WIDTH'(1);
                // Strict compare keeps the lowest bin on ties.
                if (in_search && (mag_sum > pk_mag_w)) begin
                    pk_mag_w <= mag_sum;
                    pk_bin_w <= wr_k;
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_READ;
                        rd_k     <= '0;
                        wr_k     <= '0;
                        pk_bin_w <= FIRST_BIN;
                        pk_mag_w <= '0;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        rd_k <= rd_k + ADDR_WIDTH'(1);
                        if (&rd_k) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop_last) begin
                        state    <= S_REPORT;
                        peak_bin <= pk_bin_w;
                        peak_mag <= pk_mag_w;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_mag_reader.sv
// Bench for fft_mag_reader: RAM model, table vectors, randomized frames checked against a magnitude/peak model.
module tb_fft_mag_reader;
    localparam int N = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ram_ren;
    logic [7:0]    ram_raddr;
    logic [63:0]   ram_rdata = '0;
    logic          mag_valid;
    logic          mag_ready = 1'b0;
    logic [64:0]   mag_data;
    logic [7:0]    mag_bin;
    logic          mag_last;
    logic          peak_valid;
    logic [7:0]    peak_bin;
    logic [64:0]   peak_mag;
    logic          busy;

    logic [63:0]   ram [N];
    logic [64:0]   got_mag [N];
    int            n_checks = 0;
    int            n_fail = 0;

    typedef struct {
        int          bin;
        logic [31:0] re;
        logic [31:0] im;
        logic [64:0] exp_mag;
    } vec_t;
    vec_t tv [7];

    fft_mag_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ram_ren    (ram_ren),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .mag_valid  (mag_valid),
        .mag_ready  (mag_ready),
        .mag_data   (mag_data),
        .mag_bin    (mag_bin),
        .mag_last   (mag_last),
        .peak_valid (peak_valid),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= ram[ram_raddr];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [64:0] mag_of(input logic [63:0] w);
        logic signed [64:0] r;
        logic signed [64:0] i;
        r = $signed(w[31:0]);
        i = $signed(w[63:32]);
        return r * r + i * i;
    endfunction

    // Runs one frame; abort_at >= 0 asserts rst once that many beats have been accepted.
    task automatic run_frame(input int ready_pct, input int abort_at, input bit busy_start, input bit timing);
        logic [64:0] exp_mag [N];
        logic [64:0] exp_pm;
        logic [74:0] held_beat;
        int          exp_pb;
        int          issued, acc, max_occ, first_vld, last_cyc, peak_cyc;
        bit          held, done, peak_seen;
        exp_pb = 1;
        exp_pm = '0;
        for (int k = 0; k < N; k++) begin
            exp_mag[k] = mag_of(ram[k]);
            if (k >= 1 && k < N/2 && exp_mag[k] > exp_pm) begin
                exp_pm = exp_mag[k];
                exp_pb = k;
            end
        end
        issued = 0; acc = 0; max_occ = 0; first_vld = -1; last_cyc = -1; peak_cyc = -1;
        held = 0; done = 0; peak_seen = 0; held_beat = '0;
        @(negedge clk);
        start = 1'b1;
        mag_ready = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = (busy_start && cyc == 40);
            mag_ready = ($urandom_range(99) < ready_pct);
            if (abort_at >= 0 && acc == abort_at) begin
                rst = 1'b1;
                start = 1'b0;
                mag_ready = 1'b0;
                #1;
                chk("abort_outputs_zero",
                    {ram_ren, ram_raddr, mag_valid, mag_last, mag_bin, mag_data, peak_valid, busy, peak_bin, peak_mag},
                    128'd0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("abort_quiet", {peak_valid, ram_ren, mag_valid, busy}, 4'b0000);
                end
                rst = 1'b0;
                done = 1;
            end
            if (done) break;
            if (timing && cyc == 1) chk("first_ren_addr", {ram_ren, ram_raddr}, {1'b1, 8'd0});
            if (mag_valid && first_vld < 0) first_vld = cyc;
            if (held) chk("stall_stable", {mag_valid, mag_last, mag_bin, mag_data}, {1'b1, held_beat[73:0]});
            held = mag_valid && !mag_ready;
            held_beat = {1'b0, mag_last, mag_bin, mag_data};
            if (ram_ren) begin
                if (issued - acc + 1 > max_occ) max_occ = issued - acc + 1;
                issued++;
            end
            if (mag_valid && mag_ready) begin
                if (acc < N) begin
                    chk("beat_bin", mag_bin, acc[7:0]);
                    chk("beat_mag", mag_data, exp_mag[acc]);
                    chk("beat_last", mag_last, (acc == N-1));
                    got_mag[acc] = mag_data;
                end
                if (mag_last) last_cyc = cyc;
                acc++;
            end
            if (peak_valid) begin
                peak_seen = 1;
                peak_cyc = cyc;
                chk("peak_after_all_beats", acc, N);
                chk("peak_bin", peak_bin, exp_pb[7:0]);
                chk("peak_mag", peak_mag, exp_pm);
                break;
            end
        end
        if (abort_at < 0) begin
            chk("frame_peak_seen", peak_seen, 1'b1);
            chk("frame_beats", acc, N);
            chk("frame_reads", issued, N);
            chk("occupancy_bound", (max_occ <= 4), 1'b1);
            if (timing) begin
                chk("first_valid_cycle", first_vld, 3);
                chk("last_beat_cycle", last_cyc, N + 2);
                chk("peak_cycle", peak_cyc, N + 3);
            end
            @(negedge clk);
            chk("idle_after_peak", {busy, peak_valid, ram_ren}, 3'b000);
        end
        mag_ready = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < N; k++) ram[k] = {32'd0, 32'(k)};
    endtask

    task automatic fill_zero();
        for (int k = 0; k < N; k++) ram[k] = '0;
    endtask

    initial begin
        tv[0] = '{bin: 3,   re: 32'd4,          im: 32'hFFFF_FFFD, exp_mag: 65'd25};
        tv[1] = '{bin: 10,  re: 32'h8000_0000,  im: 32'h8000_0000, exp_mag: 65'h0_8000_0000_0000_0000};
        tv[2] = '{bin: 20,  re: 32'h7FFF_FFFF,  im: 32'h7FFF_FFFF, exp_mag: 65'h0_7FFF_FFFE_0000_0002};
        tv[3] = '{bin: 40,  re: 32'hFFFF_FFFF,  im: 32'hFFFF_FFFF, exp_mag: 65'd2};
        tv[4] = '{bin: 100, re: 32'd1000,       im: 32'd0,         exp_mag: 65'd1000000};
        tv[5] = '{bin: 200, re: 32'h8000_0000,  im: 32'd0,         exp_mag: 65'h0_4000_0000_0000_0000};
        tv[6] = '{bin: 0,   re: 32'h8000_0000,  im: 32'h8000_0000, exp_mag: 65'h0_8000_0000_0000_0000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {ram_ren, ram_raddr, mag_valid, mag_last, mag_bin, mag_data, peak_valid, busy, peak_bin, peak_mag},
            128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Ramp, full throughput, cycle-exact timing
        fill_ramp();
        run_frame(100, -1, 0, 1);
        chk("ramp_peak_bin_held", peak_bin, 8'd127);
        chk("ramp_peak_mag_held", peak_mag, 65'd16129);

        // Single non-zero bin, then a tie
        fill_zero();
        ram[5] = {32'hFFFF_FFFD, 32'd4};
        run_frame(100, -1, 0, 0);
        chk("bin5_mag", got_mag[5], 65'd25);
        chk("bin5_peak", {peak_bin, peak_mag}, {8'd5, 65'd25});
        ram[9] = {32'd0, 32'd5};
        run_frame(100, -1, 0, 0);
        chk("tie_peak", {peak_bin, peak_mag}, {8'd5, 65'd25});

        // All-zero frame: first searched bin
        fill_zero();
        run_frame(100, -1, 0, 0);
        chk("zero_peak", {peak_bin, peak_mag}, {8'd1, 65'd0});

        // Random backpressure with a start pulse while busy
        fill_ramp();
        run_frame(50, -1, 1, 0);

        // Table-driven magnitude vectors
        fill_zero();
        for (int i = 0; i < 7; i++) ram[tv[i].bin] = {tv[i].im, tv[i].re};
        run_frame(100, -1, 0, 0);
        for (int i = 0; i < 7; i++) chk($sformatf("vec_bin%0d", tv[i].bin), got_mag[tv[i].bin], tv[i].exp_mag);
        chk("vec_peak", {peak_bin, peak_mag}, {8'd10, 65'h0_8000_0000_0000_0000});

        // Start coinciding with reset is dropped
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("start_during_reset", {busy, ram_ren}, 2'b00);

        // Abort mid-frame, then a clean frame
        fill_ramp();
        run_frame(100, 100, 0, 0);
        run_frame(100, -1, 0, 1);
        chk("post_abort_peak", {peak_bin, peak_mag}, {8'd127, 65'd16129});

        // Random data, random backpressure
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) ram[k] = {$urandom(), $urandom()};
            run_frame(50, -1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
